// File: rtl/seg_display_ctrl.sv
// Display content controller: arbitrates operand-entry and result values, converts the
// chosen value to 8 BCD digits by double-dabble, then applies blanking, overflow and blink.
module seg_display_ctrl #(
  parameter int BIN_W     = 27,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ent_upd,
  input  logic [BIN_W-1:0] ent_val,
  input  logic             res_upd,
  input  logic [BIN_W-1:0] res_val,
  input  logic             blink,
  output logic [3:0]       seg_data_1,
  output logic [3:0]       seg_data_2,
  output logic [3:0]       seg_data_3,
  output logic [3:0]       seg_data_4,
  output logic [3:0]       seg_data_5,
  output logic [3:0]       seg_data_6,
  output logic [3:0]       seg_data_7,
  output logic [3:0]       seg_data_8,
  output logic [7:0]       seg_data_en,
  output logic [7:0]       seg_dot_en,
  output logic             busy,
  output logic             src_shown
);
  localparam int ITER_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_e;

  state_e            state_q;
  logic              ent_pend_q, res_pend_q;
  logic [BIN_W-1:0]  ent_val_q, res_val_q;
  logic [BIN_W-1:0]  bin_q;
  logic [31:0]       bcd_q;
  logic [ITER_W-1:0] iter_q;
  logic              src_q, ovf_q;
  logic [31:0]       digits_q;
  logic [7:0]        en_q, dot_q;
  logic              src_shown_q, busy_q;
  logic [CNT_W-1:0]  blink_cnt_q;
  logic              blink_off_q;

  logic              ent_req_d, res_req_d;
  logic [BIN_W-1:0]  acc_val_d;
  logic [31:0]       bcd_adj_d;
  logic [7:0]        en_d;

  function automatic logic is_overflow(input logic [BIN_W-1:0] v);
    return 64'(v) > 64'd99_999_999;
  endfunction

  // A same-cycle update pulse counts as pending; result wins over entry.
  always_comb begin
    ent_req_d = ent_upd | ent_pend_q;
    res_req_d = res_upd | res_pend_q;
    if (res_req_d) acc_val_d = res_upd ? res_val : res_val_q;
    else           acc_val_d = ent_upd ? ent_val : ent_val_q;
  end

  always_comb begin
    bcd_adj_d = bcd_q;
    for (int k = 0; k < 8; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Digit k is lit when it or any more significant digit is nonzero; units always lit.
  always_comb begin
    logic any_nz;
    any_nz = 1'b0;
    en_d   = 8'h01;
    for (int k = 7; k >= 1; k--) begin
      any_nz  = any_nz | (|bcd_q[4*k +: 4]);
      en_d[k] = any_nz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ent_pend_q  <= 1'b0;
      res_pend_q  <= 1'b0;
      digits_q    <= '0;
      en_q        <= 8'h01;
      dot_q       <= 8'h00;
      src_shown_q <= 1'b0;
      busy_q      <= 1'b0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_q <= '0;
        blink_off_q <= ~blink_off_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + CNT_W'(1);
      end

      if (ent_upd) begin
        ent_pend_q <= 1'b1;
        ent_val_q  <= ent_val;
      end
      if (res_upd) begin
        res_pend_q <= 1'b1;
        res_val_q  <= res_val;
      end

      case (state_q)
        S_IDLE: begin
          if (res_req_d || ent_req_d) begin
            if (res_req_d) res_pend_q <= 1'b0;
            else           ent_pend_q <= 1'b0;
            bin_q   <= acc_val_d;
            ovf_q   <= is_overflow(acc_val_d);
            src_q   <= res_req_d;
            bcd_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_q  <= {bcd_adj_d[30:0], bin_q[BIN_W-1]};
          bin_q  <= bin_q << 1;
          iter_q <= iter_q + ITER_W'(1);
          if (iter_q == ITER_LAST) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          if (ovf_q) begin
            digits_q <= 32'h9999_9999;
            en_q     <= 8'hFF;
            dot_q    <= 8'hFF;
          end else begin
            digits_q <= bcd_q;
            en_q     <= en_d;
            dot_q    <= 8'h00;
          end
          src_shown_q <= src_q;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign seg_data_1  = digits_q[3:0];
  assign seg_data_2  = digits_q[7:4];
  assign seg_data_3  = digits_q[11:8];
  assign seg_data_4  = digits_q[15:12];
  assign seg_data_5  = digits_q[19:16];
  assign seg_data_6  = digits_q[23:20];
  assign seg_data_7  = digits_q[27:24];
  assign seg_data_8  = digits_q[31:28];
  assign seg_data_en = (blink && blink_off_q) ? 8'h00 : en_q;
  assign seg_dot_en  = dot_q;
  assign busy        = busy_q;
  assign src_shown   = src_shown_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: expected displays are queued at stimulus time
// and compared by a monitor whenever a conversion commits.
module tb_seg_display_ctrl;
  localparam int BIN_W     = 27;
  localparam int BLINK_DIV = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ent_upd = 1'b0, res_upd = 1'b0, blink = 1'b0;
  logic [BIN_W-1:0] ent_val = '0, res_val = '0;
  logic [3:0]       d1, d2, d3, d4, d5, d6, d7, d8;
  logic [7:0]       seg_data_en, seg_dot_en;
  logic             busy, src_shown;
  logic [31:0]      digits;

  seg_display_ctrl #(.BIN_W(BIN_W), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst),
    .ent_upd(ent_upd), .ent_val(ent_val),
    .res_upd(res_upd), .res_val(res_val),
    .blink(blink),
    .seg_data_1(d1), .seg_data_2(d2), .seg_data_3(d3), .seg_data_4(d4),
    .seg_data_5(d5), .seg_data_6(d6), .seg_data_7(d7), .seg_data_8(d8),
    .seg_data_en(seg_data_en), .seg_dot_en(seg_dot_en),
    .busy(busy), .src_shown(src_shown)
  );

  assign digits = {d8, d7, d6, d5, d4, d3, d2, d1};

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dig;
    logic [7:0]  en;
    logic [7:0]  dot;
    logic        src;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] dig, input logic [7:0] en, input logic [7:0] dot,
                          input logic src);
    exp_t x;
    x.dig = dig; x.en = en; x.dot = dot; x.src = src;
    exp_q.push_back(x);
  endtask

  // Blink phase reference: counts 0..BLINK_DIV-1, toggles on wrap, ON after reset.
  int m_cnt = 0;
  bit m_off = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
      m_off <= 1'b0;
    end else if (m_cnt == BLINK_DIV - 1) begin
      m_cnt <= 0;
      m_off <= !m_off;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Monitor: a busy fall not caused by reset marks a commit.
  logic busy_prev = 1'b0;
  logic rst_edge  = 1'b1;
  always @(posedge clk) rst_edge <= rst;
  always @(negedge clk) begin
    if (busy_prev === 1'b1 && busy === 1'b0 && !rst_edge) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_commit: got digits %h src %b, required no commit", digits, src_shown);
      end else begin
        e = exp_q.pop_front();
        check("commit_digits", digits, e.dig);
        check("commit_en", {24'h0, seg_data_en}, {24'h0, e.en});
        check("commit_dot", {24'h0, seg_dot_en}, {24'h0, e.dot});
        check("commit_src", {31'h0, src_shown}, {31'h0, e.src});
      end
    end
    busy_prev = busy;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_res(input logic [BIN_W-1:0] v);
    res_val = v; res_upd = 1'b1;
    tick();
    res_upd = 1'b0;
  endtask

  task automatic pulse_ent(input logic [BIN_W-1:0] v);
    ent_val = v; ent_upd = 1'b1;
    tick();
    ent_upd = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int k;
    k = 0;
    while (busy !== lvl && k < 100) begin
      tick();
      k++;
    end
    if (busy !== lvl) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: busy %b, required %b", name, busy, lvl);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_digits"}, digits, 32'h0);
    check({tag, "_en"}, {24'h0, seg_data_en}, 32'h01);
    check({tag, "_dot"}, {24'h0, seg_dot_en}, 32'h00);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_src"}, {31'h0, src_shown}, 32'h0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check_reset_state("reset");
    tick(2);

    // Result 12_345_678 from idle; busy lasts BIN_W+1 cycles.
    push_exp(32'h1234_5678, 8'hFF, 8'h00, 1'b1);
    pulse_res(27'd12_345_678);
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      tick();
    end
    check("busy_cycles", bc, 28);
    tick();

    // Entry 0 then 407: leading-zero blanking.
    push_exp(32'h0000_0000, 8'h01, 8'h00, 1'b0);
    pulse_ent(27'd0);
    wait_busy(1'b0, "ent0");
    tick();
    push_exp(32'h0000_0407, 8'h07, 8'h00, 1'b0);
    pulse_ent(27'd407);
    wait_busy(1'b0, "ent407");
    tick();

    // Overflow boundary: just above and exactly at the limit.
    push_exp(32'h9999_9999, 8'hFF, 8'hFF, 1'b1);
    pulse_res(27'd100_000_000);
    wait_busy(1'b0, "ovf");
    tick();
    push_exp(32'h9999_9999, 8'hFF, 8'h00, 1'b1);
    pulse_res(27'd99_999_999);
    wait_busy(1'b0, "max");
    tick();

    // Simultaneous requests: result first, then the newest entry value (77 replaces 55).
    push_exp(32'h0000_0066, 8'h03, 8'h00, 1'b1);
    push_exp(32'h0000_0077, 8'h03, 8'h00, 1'b0);
    ent_val = 27'd55; res_val = 27'd66;
    ent_upd = 1'b1; res_upd = 1'b1;
    tick();
    ent_upd = 1'b0; res_upd = 1'b0;
    tick(5);
    pulse_ent(27'd77);
    wait_busy(1'b0, "arb_first");
    wait_busy(1'b1, "arb_second_start");
    wait_busy(1'b0, "arb_second");
    tick();

    // Blink on value 9.
    push_exp(32'h0000_0009, 8'h01, 8'h00, 1'b0);
    pulse_ent(27'd9);
    wait_busy(1'b0, "blinkval");
    tick();
    blink = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("blink_en", {24'h0, seg_data_en}, m_off ? 32'h00 : 32'h01);
    end
    check("blink_digits", digits, 32'h9);
    @(posedge clk); #1;
    blink = 1'b0;
    @(negedge clk);
    check("blink_release_en", {24'h0, seg_data_en}, 32'h01);
    tick();

    // Reset in the middle of a conversion: no commit, nothing left pending.
    pulse_res(27'd999);
    tick(9);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check_reset_state("midrst");
    bc = 0;
    repeat (40) begin
      tick();
      if (busy !== 1'b0) bc++;
    end
    check("midrst_no_busy", bc, 0);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
